// File: rtl/c1541_track_loader.sv
// c1541_track_loader
// Moves one D64 track at a time between the SD block interface and the
// 8 KB track buffer used by the GCR stage. A dirty track is written back
// before the next one is read. A track change or an image remount that
// arrives mid-transfer is acted on once the current transfer has finished.
module c1541_track_loader (
    input  logic        clk32,
    input  logic        reset_n,

    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic        img_present,
    input  logic        dirty_set,

    output logic        ready,
    output logic        busy,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,

    output logic [12:0] buf_addr,
    output logic [7:0]  buf_dout,
    input  logic [7:0]  buf_din,
    output logic        buf_we
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_XFER = 3'd2,
        RD_REQ  = 3'd3,
        RD_XFER = 3'd4
    } state_t;

    // Tracks outside 1..35 are pinned to the nearest valid track.
    function automatic logic [5:0] clamp_track(input logic [5:0] t);
        if (t == 6'd0) begin
            return 6'd1;
        end else if (t > 6'd35) begin
            return 6'd35;
        end else begin
            return t;
        end
    endfunction

    // The 1541 uses four speed zones, with fewer sectors on the inner tracks.
    function automatic logic [4:0] sectors_per_track(input logic [5:0] t);
        if (t < 6'd18) begin
            return 5'd21;
        end else if (t < 6'd25) begin
            return 5'd19;
        end else if (t < 6'd31) begin
            return 5'd18;
        end else begin
            return 5'd17;
        end
    endfunction

    // First 256-byte block of a track within the image.
    function automatic logic [9:0] track_start(input logic [5:0] t);
        logic [9:0] tw;
        tw = {4'd0, t};
        if (t < 6'd18) begin
            return (tw - 10'd1) * 10'd21;
        end else if (t < 6'd25) begin
            return 10'd357 + (tw - 10'd18) * 10'd19;
        end else if (t < 6'd31) begin
            return 10'd490 + (tw - 10'd25) * 10'd18;
        end else begin
            return 10'd598 + (tw - 10'd31) * 10'd17;
        end
    endfunction

    state_t      state_reg, state_next;
    logic [4:0]  sector_reg, sector_next;
    logic [5:0]  cur_track_reg, cur_track_next;
    logic [5:0]  xfer_track_reg, xfer_track_next;
    logic        dirty_reg, dirty_next;
    logic        reload_pend_reg, reload_pend_next;
    logic        mount_pend_reg, mount_pend_next;
    logic        ready_reg, ready_next;
    logic        ack_d_reg;

    logic [5:0]  req_track;
    logic [4:0]  last_sector;
    logic        ack_fall;
    logic [9:0]  block_lba;

    assign req_track   = clamp_track(track);
    assign last_sector = sectors_per_track(xfer_track_reg) - 5'd1;
    // The SD side signals the end of a block by dropping sd_ack.
    assign ack_fall    = ack_d_reg & ~sd_ack;
    assign block_lba   = track_start(xfer_track_reg) + {5'd0, sector_reg};

    // State register.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            sector_reg      <= 5'd0;
            cur_track_reg   <= 6'd0;
            xfer_track_reg  <= 6'd0;
            dirty_reg       <= 1'b0;
            reload_pend_reg <= 1'b1;
            mount_pend_reg  <= 1'b0;
            ready_reg       <= 1'b0;
            ack_d_reg       <= 1'b0;
        end else begin
            sector_reg      <= sector_next;
            cur_track_reg   <= cur_track_next;
            xfer_track_reg  <= xfer_track_next;
            dirty_reg       <= dirty_next;
            reload_pend_reg <= reload_pend_next;
            mount_pend_reg  <= mount_pend_next;
            ready_reg       <= ready_next;
            ack_d_reg       <= sd_ack;
        end
    end

    // Next-state logic: start, sequence and finish track transfers.
    always_comb begin
        state_next       = state_reg;
        sector_next      = sector_reg;
        cur_track_next   = cur_track_reg;
        xfer_track_next  = xfer_track_reg;
        dirty_next       = dirty_reg;
        reload_pend_next = reload_pend_reg;
        mount_pend_next  = mount_pend_reg;

        ready_next = (state_reg == IDLE) & img_present &
                     (cur_track_reg == req_track) & ~reload_pend_reg;

        // The GCR stage may only modify the buffer while it holds a valid track.
        if (dirty_set && ready_reg) begin
            dirty_next = 1'b1;
        end

        // A remount during a transfer is remembered until the track is done.
        if (img_mounted && (state_reg != IDLE)) begin
            mount_pend_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (img_mounted) begin
                    // Old image contents are stale; hold one cycle so the
                    // cleared dirty flag is seen before deciding what to do.
                    reload_pend_next = 1'b1;
                    dirty_next       = 1'b0;
                end else if (img_present &&
                             ((req_track != cur_track_reg) || reload_pend_reg)) begin
                    sector_next = 5'd0;
                    if (dirty_next) begin
                        state_next      = WB_REQ;
                        xfer_track_next = cur_track_reg;
                    end else begin
                        state_next      = RD_REQ;
                        xfer_track_next = req_track;
                    end
                end
            end

            RD_REQ: begin
                if (sd_ack) begin
                    state_next = RD_XFER;
                end
            end

            RD_XFER: begin
                if (ack_fall) begin
                    if (!img_present) begin
                        // Image vanished: the buffer is only partly loaded.
                        state_next       = IDLE;
                        sector_next      = 5'd0;
                        reload_pend_next = 1'b1;
                    end else if (sector_reg == last_sector) begin
                        state_next       = IDLE;
                        sector_next      = 5'd0;
                        cur_track_next   = xfer_track_reg;
                        reload_pend_next = mount_pend_reg | img_mounted;
                        mount_pend_next  = 1'b0;
                        dirty_next       = 1'b0;
                    end else begin
                        state_next  = RD_REQ;
                        sector_next = sector_reg + 5'd1;
                    end
                end
            end

            WB_REQ: begin
                if (sd_ack) begin
                    state_next = WB_XFER;
                end
            end

            WB_XFER: begin
                if (ack_fall) begin
                    if (!img_present) begin
                        // Buffer still intact and dirty; write-back restarts later.
                        state_next  = IDLE;
                        sector_next = 5'd0;
                    end else if (sector_reg == last_sector) begin
                        state_next      = RD_REQ;
                        sector_next     = 5'd0;
                        dirty_next      = 1'b0;
                        xfer_track_next = req_track;
                    end else begin
                        state_next  = WB_REQ;
                        sector_next = sector_reg + 5'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready       = ready_reg;
    assign busy        = (state_reg != IDLE);
    assign sd_rd       = (state_reg == RD_REQ);
    assign sd_wr       = (state_reg == WB_REQ);
    assign sd_lba      = busy ? {22'd0, block_lba} : 32'd0;
    assign sd_buff_din = buf_din;
    assign buf_we      = (state_reg == RD_XFER) & sd_buff_wr;
    assign buf_addr    = busy ? {sector_reg, sd_buff_addr} : 13'd0;
    assign buf_dout    = (state_reg == RD_XFER) ? sd_buff_dout : 8'd0;

endmodule

// File: tb/tb_c1541_track_loader.sv
// Bench for c1541_track_loader: an SD-card responder with random latency and
// random byte subsets, a track-buffer RAM, and a transaction-level model of
// which blocks must be written back and read for each track change.
module tb_c1541_track_loader;

    logic        clk32 = 1'b0;
    logic        reset_n;
    logic [5:0]  track;
    logic        img_mounted;
    logic        img_present;
    logic        dirty_set;
    logic        ready;
    logic        busy;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [12:0] buf_addr;
    logic [7:0]  buf_dout;
    logic [7:0]  buf_din;
    logic        buf_we;

    always #15 clk32 = ~clk32;

    c1541_track_loader dut (
        .clk32        (clk32),
        .reset_n      (reset_n),
        .track        (track),
        .img_mounted  (img_mounted),
        .img_present  (img_present),
        .dirty_set    (dirty_set),
        .ready        (ready),
        .busy         (busy),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .buf_addr     (buf_addr),
        .buf_dout     (buf_dout),
        .buf_din      (buf_din),
        .buf_we       (buf_we)
    );

    typedef struct {
        bit wr;
        int lba;
    } xfer_t;

    xfer_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         spt_tab[36];
    int         start_tab[36];
    logic [7:0] mem[8192];
    logic [7:0] model_buf[8192];
    bit         stall = 1'b0;
    int         m_cur   = 0;
    bit         m_dirty = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_spt(input int t);
        if (t <= 17) return 21;
        if (t <= 24) return 19;
        if (t <= 30) return 18;
        return 17;
    endfunction

    function automatic int clamp(input int t);
        if (t < 1) return 1;
        if (t > 35) return 35;
        return t;
    endfunction

    function automatic int lba_track(input int lba);
        for (int t = 1; t <= 35; t++) begin
            if (lba >= start_tab[t] && lba < start_tab[t] + spt_tab[t]) return t;
        end
        return 1;
    endfunction

    // Track buffer RAM with one-cycle read latency.
    always @(posedge clk32) begin
        if (buf_we) mem[buf_addr] <= buf_dout;
        buf_din <= mem[buf_addr];
    end

    // Serve one block request: check it against the expected sequence, then
    // move a few random bytes in the requested direction.
    task automatic serve();
        bit         is_wr;
        int         lba;
        int         sec;
        int         nb;
        xfer_t      e;
        logic [7:0] a;
        logic [7:0] d;
        logic [12:0] idx;
        is_wr = sd_wr;
        lba   = int'(sd_lba);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got wr=%0d lba=%0d, expected no request", is_wr, lba);
        end else begin
            e = exp_q.pop_front();
            chk("req_kind", 64'(is_wr), 64'(e.wr));
            chk("req_lba", 64'(lba), 64'(e.lba));
        end
        sec = lba - start_tab[lba_track(lba)];
        while (stall) @(posedge clk32);
        repeat ($urandom_range(0, 3)) @(posedge clk32);
        @(posedge clk32);
        #1 sd_ack = 1'b1;
        nb = $urandom_range(1, 4);
        for (int i = 0; i < nb; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            idx = {sec[4:0], a};
            @(posedge clk32);
            #1;
            sd_buff_addr = a;
            if (!is_wr) begin
                sd_buff_dout = d;
                sd_buff_wr   = 1'b1;
            end
            @(negedge clk32);
            chk("buf_addr", 64'(buf_addr), 64'(idx));
            if (!is_wr) begin
                chk("buf_we_rd", 64'(buf_we), 64'd1);
                chk("buf_dout", 64'(buf_dout), 64'(d));
                model_buf[idx] = d;
            end else begin
                @(posedge clk32);
                @(negedge clk32);
                chk("sd_buff_din", 64'(sd_buff_din), 64'(model_buf[idx]));
            end
        end
        @(posedge clk32);
        #1;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
    endtask

    // SD responder.
    initial begin
        sd_ack       = 1'b0;
        sd_buff_addr = 8'd0;
        sd_buff_dout = 8'd0;
        sd_buff_wr   = 1'b0;
        forever begin
            @(negedge clk32);
            if (reset_n === 1'b1 && (sd_rd === 1'b1 || sd_wr === 1'b1)) serve();
        end
    end

    // Per-cycle protocol checks.
    always @(negedge clk32) begin
        chk("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'd0);
        chk("busy_vs_ready", 64'(busy & ready), 64'd0);
        chk("buf_we_only_on_data", 64'(buf_we), 64'(sd_buff_wr));
        if (busy === 1'b0) chk("idle_no_request", 64'(sd_rd | sd_wr), 64'd0);
    end

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic set_track(input int t);
        tick();
        track = 6'(t);
        tick();
    endtask

    task automatic push_load(input int t, input bit wr);
        for (int s = 0; s < spt_tab[t]; s++) begin
            xfer_t x;
            x.wr  = wr;
            x.lba = start_tab[t] + s;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_done(input string name, input bit strict);
        int c = 0;
        while (!(ready === 1'b1 && exp_q.size() == 0) && c < 20000) begin
            @(negedge clk32);
            if (strict && exp_q.size() != 0) chk({name, "_ready_low"}, 64'(ready), 64'd0);
            c++;
        end
        chk({name, "_done"}, 64'(c < 20000), 64'd1);
    endtask

    task automatic wait_q(input int n);
        int c = 0;
        while (exp_q.size() > n && c < 20000) begin
            @(negedge clk32);
            c++;
        end
        chk("wait_queue_progress", 64'(c < 20000), 64'd1);
    endtask

    task automatic pulse_dirty();
        tick();
        dirty_set = 1'b1;
        tick();
        dirty_set = 1'b0;
        m_dirty = 1'b1;
    endtask

    task automatic go_track(input int t);
        int ct;
        ct = clamp(t);
        if (ct != m_cur) begin
            if (m_dirty) push_load(m_cur, 1'b1);
            push_load(ct, 1'b0);
            m_dirty = 1'b0;
            m_cur   = ct;
            set_track(t);
            wait_done("load", 1'b1);
        end else begin
            set_track(t);
            repeat (5) tick();
            chk("same_track_ready", 64'(ready), 64'd1);
        end
    endtask

    initial begin
        #(30 * 150000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        start_tab[0] = 0;
        spt_tab[0]   = 0;
        start_tab[1] = 0;
        spt_tab[1]   = model_spt(1);
        for (int t = 2; t <= 35; t++) begin
            spt_tab[t]   = model_spt(t);
            start_tab[t] = start_tab[t-1] + spt_tab[t-1];
        end
        for (int i = 0; i < 8192; i++) begin
            mem[i]       = 8'd0;
            model_buf[i] = 8'd0;
        end

        // Hand-computed pins on the block map.
        chk("start_18", 64'(start_tab[18]), 64'd357);
        chk("spt_18", 64'(spt_tab[18]), 64'd19);
        chk("start_35", 64'(start_tab[35]), 64'd666);
        chk("spt_35", 64'(spt_tab[35]), 64'd17);
        chk("start_3", 64'(start_tab[3]), 64'd42);
        chk("start_25", 64'(start_tab[25]), 64'd490);

        reset_n     = 1'b0;
        track       = 6'd18;
        img_mounted = 1'b0;
        img_present = 1'b0;
        dirty_set   = 1'b0;
        repeat (3) @(negedge clk32);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_wr), 64'd0);
        chk("rst_sd_lba", 64'(sd_lba), 64'd0);
        chk("rst_buf_addr", 64'(buf_addr), 64'd0);
        chk("rst_buf_dout", 64'(buf_dout), 64'd0);
        chk("rst_buf_we", 64'(buf_we), 64'd0);

        // No image: nothing may start.
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("noimg_ready", 64'(ready), 64'd0);
        chk("noimg_busy", 64'(busy), 64'd0);

        // First load of track 18.
        push_load(18, 1'b0);
        m_cur = 18;
        tick();
        img_present = 1'b1;
        wait_done("trk18", 1'b1);

        go_track(35);
        go_track(0);

        // Dirty track 1, move to 2: write-back then read.
        pulse_dirty();
        go_track(2);

        // 1 -> 2 -> 3 while 2 is loading.
        go_track(1);
        push_load(2, 1'b0);
        push_load(3, 1'b0);
        m_cur = 3;
        set_track(2);
        wait_q(30);
        set_track(3);
        wait_done("trk2_then_3", 1'b1);

        // Remount and dirty pulse mid-load of track 5.
        push_load(5, 1'b0);
        push_load(5, 1'b0);
        m_cur = 5;
        set_track(5);
        wait_q(30);
        tick();
        img_mounted = 1'b1;
        dirty_set   = 1'b1;
        tick();
        img_mounted = 1'b0;
        dirty_set   = 1'b0;
        wait_done("trk5_remount", 1'b1);
        go_track(6);

        // Image removed: a track change must not start a load.
        tick();
        img_present = 1'b0;
        set_track(9);
        repeat (30) tick();
        chk("gone_ready", 64'(ready), 64'd0);
        chk("gone_busy", 64'(busy), 64'd0);
        push_load(9, 1'b0);
        m_cur = 9;
        tick();
        img_present = 1'b1;
        wait_done("trk9_after_present", 1'b1);

        // SD side stalls: request must be held with no buffer activity.
        stall = 1'b1;
        push_load(12, 1'b0);
        m_cur = 12;
        set_track(12);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk32);
            if (i % 100 == 0 || i == 999) begin
                chk("stall_sd_rd", 64'(sd_rd), 64'd1);
                chk("stall_busy", 64'(busy), 64'd1);
                chk("stall_ready", 64'(ready), 64'd0);
                chk("stall_buf_we", 64'(buf_we), 64'd0);
            end
        end
        stall = 1'b0;
        wait_done("trk12_after_stall", 1'b1);

        // Remount while idle: same track reloads, dirty data discarded.
        pulse_dirty();
        m_dirty = 1'b0;
        push_load(m_cur, 1'b0);
        tick();
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        wait_done("idle_remount", 1'b0);

        // Random track walk with random dirty marks.
        for (int it = 0; it < 8; it++) begin
            int t;
            if ($urandom_range(0, 1) == 1) pulse_dirty();
            if ($urandom_range(0, 4) == 0) t = m_cur;
            else t = $urandom_range(0, 63);
            go_track(t);
        end

        repeat (10) tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_ready", 64'(ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c1541_track_loader.md
C1541_TRACK_LOADER -- requirements
Module: c1541_track_loader

Interface
REQ-001 clk32  in  1  system clock, 32 MHz; all logic on its rising edge.
REQ-002 reset_n  in  1  asynchronous active-low reset.
REQ-003 track  in  6  requested head track, 1..35; 0 is treated as 1, values >35 as 35.
REQ-004 img_mounted  in  1  one-cycle pulse: a new D64 image is mounted.
REQ-005 img_present  in  1  level: an image is available.
REQ-006 dirty_set  in  1  one-cycle pulse from the GCR stage when it writes a track-buffer byte.
REQ-007 ready  out  1  track buffer holds the requested track; drives the GCR stage's ram_ready.
REQ-008 busy  out  1  a write-back or load is in progress.
REQ-009 sd_lba  out  32  256-byte block index within the image.
REQ-010 sd_rd, sd_wr  out  1 each  block read and write requests.
REQ-011 sd_ack  in  1  SD side owns the transfer while high.
REQ-012 sd_buff_addr  in  8  byte index within the block.
REQ-013 sd_buff_dout  in  8  read data from SD.
REQ-014 sd_buff_wr  in  1  sd_buff_dout valid.
REQ-015 sd_buff_din  out  8  write data to SD; driven directly from buf_din.
REQ-016 buf_addr  out  13  track-buffer address {sector[4:0], byte[7:0]}.
REQ-017 buf_dout  out  8  data to the track buffer.
REQ-018 buf_din  in  8  track-buffer read data, one-cycle latency.
REQ-019 buf_we  out  1  track-buffer write strobe.

Function
REQ-020 Sectors per track: 21 for tracks 1-17, 19 for 18-24, 18 for 25-30, 17 for 31-35.
REQ-021 Track start block:
- t<18: (t-1)*21
- t<25: 357+(t-18)*19
- t<31: 490+(t-25)*18
- else: 598+(t-31)*17
REQ-022 sd_lba = start(track) + sector count; the result is zero-extended to 32 bits.
REQ-023 State machine states: IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER.
REQ-024 IDLE to RD_REQ when img_present=1 and either the clamped track differs from cur_track or reload_pend=1, with dirty=0.
REQ-025 Under the same condition with dirty=1, IDLE goes to WB_REQ for cur_track instead.
REQ-026 On entering RD_REQ or WB_REQ, the sector counter is 0.
REQ-027 RD_REQ: sd_rd=1 until sd_ack is sampled high, then clear; go to RD_XFER.
REQ-028 RD_XFER, on each sd_buff_wr: buf_we=1, buf_addr={sector, sd_buff_addr}, buf_dout=sd_buff_dout.
REQ-029 RD_XFER completion on the sd_ack falling edge:
- if sector = max-1, latch cur_track, clear reload_pend, go to IDLE;
- otherwise increment sector and return to RD_REQ.
REQ-030 WB_REQ and WB_XFER mirror RD_REQ and RD_XFER using sd_wr; buf_addr={sector, sd_buff_addr} combinationally.
REQ-031 After the last WB sector, clear dirty and go to RD_REQ for the new track.
REQ-032 sd_rd and sd_wr are never asserted together; each is asserted for at least 1 cycle before sd_ack.
REQ-033 ready = (state==IDLE) & img_present & (cur_track==clamped track) & ~reload_pend, registered.
REQ-034 busy = (state != IDLE).
REQ-035 dirty is set by dirty_set only while ready=1; dirty_set with ready=0 is ignored.
REQ-036 A track change during a load is not aborted; the current track completes, then IDLE reevaluates on the next cycle.
REQ-037 img_mounted in IDLE: set reload_pend and clear dirty (the old image's data is discarded).
REQ-038 img_mounted while busy: latched and applied on return to IDLE.
REQ-039 img_present=0: no new transfers start and ready=0; an in-flight block completes.

Reset
REQ-040 reset_n low asynchronously forces:
- state=IDLE, cur_track=0, sector=0, dirty=0, reload_pend=1;
- sd_rd=0, sd_wr=0, buf_we=0, ready=0, busy=0, sd_lba=0, buf_addr=0, buf_dout=0.
REQ-041 After release, the first load starts only when img_present=1; a reset mid-transfer abandons it with no write-back.

Verification
REQ-042 Reset, img_present=1, track=18 -> 19 reads at lba 357..375, buf_we data at {s, addr}; ready rises after the last sd_ack falls.
REQ-043 track=35 -> lba 666..682 (17 blocks); track=0 -> loads track 1 at lba 0..20.
REQ-044 Track 1 loaded, dirty_set pulse, track->2 -> 21 sd_wr blocks at lba 0..20 with sd_buff_din=buf_din, then 21 reads at lba 21..41; dirty=0 at the end.
REQ-045 Track changes 1->2->3 while loading 2 -> track 2 completes, then track 3 loads (lba 42..62); ready stays 0 until track 3 completes.
REQ-046 img_mounted mid-load of track 5 -> track 5 finishes, then the same track reloads; dirty_set during the load does not trigger a later write-back.
REQ-047 sd_ack held low for 1000 cycles -> sd_rd stays 1, busy=1, ready=0, with no buffer writes.
